// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared types and default widths for the K-tiled matmul sequencer.
// Every file in this block imports this package.
package matmul_tile_sequencer_pkg;

    localparam int AWIDTH_DEF            = 10;
    localparam int ADDR_STRIDE_WIDTH_DEF = 8;
    localparam int MASK_WIDTH_DEF        = 8;
    localparam int TILE_CNT_WIDTH_DEF    = 4;
    localparam int PERF_WIDTH_DEF        = 32;
    localparam int NUM_ADDR_GEN          = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_t;

    function automatic logic state_is_busy(input seq_state_t s);
        return (s == ST_LAUNCH) || (s == ST_WAIT_DONE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/matmul_tile_sequencer_if.sv
// Control bus between the tile sequencer (master) and the 8x8 matmul core (slave).
interface matmul_tile_sequencer_if
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int AWIDTH            = AWIDTH_DEF,
    parameter int ADDR_STRIDE_WIDTH = ADDR_STRIDE_WIDTH_DEF,
    parameter int MASK_WIDTH        = MASK_WIDTH_DEF
);
    logic                         start_mat_mul;
    logic                         done_mat_mul;
    logic [AWIDTH-1:0]            address_mat_a;
    logic [AWIDTH-1:0]            address_mat_b;
    logic [AWIDTH-1:0]            address_mat_c;
    logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a;
    logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b;
    logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c;
    logic                         save_output_to_accum;
    logic                         add_accum_to_output;
    logic [MASK_WIDTH-1:0]        validity_mask_a_rows;
    logic [MASK_WIDTH-1:0]        validity_mask_a_cols_b_rows;
    logic [MASK_WIDTH-1:0]        validity_mask_b_cols;

    modport master (
        output start_mat_mul,
        input  done_mat_mul,
        output address_mat_a, address_mat_b, address_mat_c,
        output address_stride_a, address_stride_b, address_stride_c,
        output save_output_to_accum, add_accum_to_output,
        output validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols
    );

    modport slave (
        input  start_mat_mul,
        output done_mat_mul,
        input  address_mat_a, address_mat_b, address_mat_c,
        input  address_stride_a, address_stride_b, address_stride_c,
        input  save_output_to_accum, add_accum_to_output,
        input  validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols
    );

endinterface

// File: rtl/matmul_tile_sequencer_tile_addr_gen.sv
// One per-tile address accumulator: load latches base and step, advance adds step.
// The sum wraps modulo 2^AWIDTH.
module tile_addr_gen
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [AWIDTH-1:0] i_base,
    input  logic [AWIDTH-1:0] i_step,
    output logic [AWIDTH-1:0] o_addr
);

    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] r_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_step <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
            r_step <= i_step;
        end else if (i_advance) begin
            r_addr <= r_addr + r_step;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Runs NUM_K accumulated tiles on the matmul core from a single host start,
// then holds a sticky done (and aborted flag) until the host clears it.
module matmul_tile_sequencer
    import matmul_tile_sequencer_pkg::*;
#(
    parameter int AWIDTH            = AWIDTH_DEF,
    parameter int ADDR_STRIDE_WIDTH = ADDR_STRIDE_WIDTH_DEF,
    parameter int MASK_WIDTH        = MASK_WIDTH_DEF,
    parameter int TILE_CNT_WIDTH    = TILE_CNT_WIDTH_DEF,
    parameter int PERF_WIDTH        = PERF_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_reg,
    input  logic                         clear_done_reg,
    input  logic                         abort,
    input  logic [TILE_CNT_WIDTH-1:0]    num_k_tiles,
    input  logic [AWIDTH-1:0]            base_addr_a,
    input  logic [AWIDTH-1:0]            base_addr_b,
    input  logic [AWIDTH-1:0]            base_addr_c,
    input  logic [AWIDTH-1:0]            tile_step_a,
    input  logic [AWIDTH-1:0]            tile_step_b,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride_a_in,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride_b_in,
    input  logic [ADDR_STRIDE_WIDTH-1:0] stride_c_in,
    input  logic [MASK_WIDTH-1:0]        mask_a_rows_in,
    input  logic [MASK_WIDTH-1:0]        mask_b_cols_in,
    input  logic [MASK_WIDTH-1:0]        mask_k_full,
    input  logic [MASK_WIDTH-1:0]        mask_k_last,
    matmul_tile_sequencer_if.master      core,
    output logic                         busy,
    output logic                         done_reg,
    output logic                         aborted,
    output logic [TILE_CNT_WIDTH-1:0]    tile_idx,
    output logic [PERF_WIDTH-1:0]        busy_cycles
);

    seq_state_t r_state;
    seq_state_t w_state_next;

    logic [TILE_CNT_WIDTH-1:0]    r_num_k;
    logic [TILE_CNT_WIDTH-1:0]    r_tile_idx;
    logic [AWIDTH-1:0]            r_addr_c;
    logic [ADDR_STRIDE_WIDTH-1:0] r_stride_a;
    logic [ADDR_STRIDE_WIDTH-1:0] r_stride_b;
    logic [ADDR_STRIDE_WIDTH-1:0] r_stride_c;
    logic [MASK_WIDTH-1:0]        r_mask_rows;
    logic [MASK_WIDTH-1:0]        r_mask_cols;
    logic [MASK_WIDTH-1:0]        r_mask_k_full;
    logic [MASK_WIDTH-1:0]        r_mask_k_last;
    logic [MASK_WIDTH-1:0]        r_mask_k;
    logic                         r_start;
    logic                         r_save;
    logic                         r_add;
    logic                         r_done;
    logic                         r_aborted;
    logic                         r_abort_pend;
    logic [PERF_WIDTH-1:0]        r_busy_cycles;

    logic w_busy;
    logic w_last_tile;
    logic w_abort_seen;
    logic w_launch_first;
    logic w_zero_run;
    logic w_finish;
    logic w_advance;

    logic [AWIDTH-1:0] w_base [NUM_ADDR_GEN];
    logic [AWIDTH-1:0] w_step [NUM_ADDR_GEN];
    logic [AWIDTH-1:0] w_addr [NUM_ADDR_GEN];

    assign w_busy       = state_is_busy(r_state);
    assign w_last_tile  = (r_tile_idx == (r_num_k - TILE_CNT_WIDTH'(1)));
    assign w_abort_seen = r_abort_pend | abort;

    always_comb begin
        w_state_next   = r_state;
        w_launch_first = 1'b0;
        w_zero_run     = 1'b0;
        w_finish       = 1'b0;
        w_advance      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_reg) begin
                    if (num_k_tiles == '0) begin
                        w_zero_run   = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_launch_first = 1'b1;
                        w_state_next   = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: w_state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (core.done_mat_mul) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait for the core to drop done so the next start is seen as a new handshake.
                if (!core.done_mat_mul) begin
                    if (w_abort_seen || w_last_tile) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_LAUNCH;
                    end
                end
            end
            ST_DONE: begin
                if (clear_done_reg) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_k       <= '0;
            r_tile_idx    <= '0;
            r_addr_c      <= '0;
            r_stride_a    <= '0;
            r_stride_b    <= '0;
            r_stride_c    <= '0;
            r_mask_rows   <= '0;
            r_mask_cols   <= '0;
            r_mask_k_full <= '0;
            r_mask_k_last <= '0;
            r_mask_k      <= '0;
            r_start       <= 1'b0;
            r_save        <= 1'b0;
            r_add         <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_busy_cycles <= '0;
        end else begin
            if (w_busy && (r_busy_cycles != '1)) r_busy_cycles <= r_busy_cycles + PERF_WIDTH'(1);

            if (w_busy && abort) r_abort_pend <= 1'b1;

            if (w_zero_run) begin
                r_done        <= 1'b1;
                r_aborted     <= 1'b0;
                r_busy_cycles <= '0;
            end

            if (w_launch_first) begin
                r_num_k       <= num_k_tiles;
                r_tile_idx    <= '0;
                r_addr_c      <= base_addr_c;
                r_stride_a    <= stride_a_in;
                r_stride_b    <= stride_b_in;
                r_stride_c    <= stride_c_in;
                r_mask_rows   <= mask_a_rows_in;
                r_mask_cols   <= mask_b_cols_in;
                r_mask_k_full <= mask_k_full;
                r_mask_k_last <= mask_k_last;
                r_abort_pend  <= 1'b0;
                r_busy_cycles <= '0;
            end

            // First tile writes the accumulator fresh, the last one releases it to the output.
            if (r_state == ST_LAUNCH) begin
                r_save   <= !w_last_tile;
                r_add    <= (r_tile_idx != '0);
                r_mask_k <= w_last_tile ? r_mask_k_last : r_mask_k_full;
                r_start  <= 1'b1;
            end

            if ((r_state == ST_WAIT_DONE) && core.done_mat_mul) r_start <= 1'b0;

            if (w_advance) r_tile_idx <= r_tile_idx + TILE_CNT_WIDTH'(1);

            if (w_finish) begin
                r_done    <= 1'b1;
                r_aborted <= w_abort_seen;
            end

            if ((r_state == ST_DONE) && clear_done_reg) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end
        end
    end

    assign w_base[0] = base_addr_a;
    assign w_base[1] = base_addr_b;
    assign w_step[0] = tile_step_a;
    assign w_step[1] = tile_step_b;

    generate
        for (genvar gi = 0; gi < NUM_ADDR_GEN; gi++) begin : g_addr_gen
            tile_addr_gen #(
                .AWIDTH (AWIDTH)
            ) u_addr_gen (
                .clk       (clk),
                .reset     (reset),
                .i_load    (w_launch_first),
                .i_advance (w_advance),
                .i_base    (w_base[gi]),
                .i_step    (w_step[gi]),
                .o_addr    (w_addr[gi])
            );
        end
    endgenerate

    assign core.start_mat_mul               = r_start;
    assign core.address_mat_a               = w_addr[0];
    assign core.address_mat_b               = w_addr[1];
    assign core.address_mat_c               = r_addr_c;
    assign core.address_stride_a            = r_stride_a;
    assign core.address_stride_b            = r_stride_b;
    assign core.address_stride_c            = r_stride_c;
    assign core.save_output_to_accum        = r_save;
    assign core.add_accum_to_output         = r_add;
    assign core.validity_mask_a_rows        = r_mask_rows;
    assign core.validity_mask_a_cols_b_rows = r_mask_k;
    assign core.validity_mask_b_cols        = r_mask_cols;

    assign busy        = w_busy;
    assign done_reg    = r_done;
    assign aborted     = r_aborted;
    assign tile_idx    = r_tile_idx;
    assign busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for the tile sequencer with a simple core model that raises
// done 5 cycles after start and drops it once start is released.
module tb_matmul_tile_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_reg = 1'b0;
    logic        clear_done_reg = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  num_k_tiles = '0;
    logic [9:0]  base_addr_a = '0, base_addr_b = '0, base_addr_c = '0;
    logic [9:0]  tile_step_a = '0, tile_step_b = '0;
    logic [7:0]  stride_a_in = '0, stride_b_in = '0, stride_c_in = '0;
    logic [7:0]  mask_a_rows_in = '0, mask_b_cols_in = '0;
    logic [7:0]  mask_k_full = '0, mask_k_last = '0;
    logic        busy, done_reg, aborted;
    logic [3:0]  tile_idx;
    logic [31:0] busy_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    logic prev_start = 1'b0;
    logic [2:0] core_cnt;
    logic [9:0] rec_a[$];
    logic [9:0] rec_b[$];
    logic [1:0] rec_sa[$];
    logic [7:0] rec_mk[$];

    matmul_tile_sequencer_if #(.AWIDTH(10), .ADDR_STRIDE_WIDTH(8), .MASK_WIDTH(8)) core_bus ();

    matmul_tile_sequencer #(
        .AWIDTH(10), .ADDR_STRIDE_WIDTH(8), .MASK_WIDTH(8), .TILE_CNT_WIDTH(4), .PERF_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .start_reg(start_reg), .clear_done_reg(clear_done_reg),
        .abort(abort), .num_k_tiles(num_k_tiles),
        .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .base_addr_c(base_addr_c),
        .tile_step_a(tile_step_a), .tile_step_b(tile_step_b),
        .stride_a_in(stride_a_in), .stride_b_in(stride_b_in), .stride_c_in(stride_c_in),
        .mask_a_rows_in(mask_a_rows_in), .mask_b_cols_in(mask_b_cols_in),
        .mask_k_full(mask_k_full), .mask_k_last(mask_k_last),
        .core(core_bus.master),
        .busy(busy), .done_reg(done_reg), .aborted(aborted),
        .tile_idx(tile_idx), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    // Core model: done rises on the 5th edge that sees start, falls once start drops.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_bus.done_mat_mul <= 1'b0;
            core_cnt <= '0;
        end else if (!core_bus.start_mat_mul) begin
            core_bus.done_mat_mul <= 1'b0;
            core_cnt <= '0;
        end else if (!core_bus.done_mat_mul) begin
            if (core_cnt == 3'd4) core_bus.done_mat_mul <= 1'b1;
            else                  core_cnt <= core_cnt + 3'd1;
        end
    end

    // Record the core controls at every new start pulse.
    always @(negedge clk) begin
        if (core_bus.start_mat_mul && !prev_start) begin
            n_starts++;
            rec_a.push_back(core_bus.address_mat_a);
            rec_b.push_back(core_bus.address_mat_b);
            rec_sa.push_back({core_bus.save_output_to_accum, core_bus.add_accum_to_output});
            rec_mk.push_back(core_bus.validity_mask_a_cols_b_rows);
        end
        prev_start = core_bus.start_mat_mul;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_recs();
        n_starts = 0;
        rec_a.delete(); rec_b.delete(); rec_sa.delete(); rec_mk.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start_reg = 1'b1;
        @(negedge clk) start_reg = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_reg) break;
            @(negedge clk);
        end
        check_val({tag, "_done"}, done_reg, 1);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_starts >= n) break;
            @(negedge clk);
        end
        check_val({tag, "_start_seen"}, n_starts >= n, 1);
    endtask

    task automatic clear_done();
        @(negedge clk) clear_done_reg = 1'b1;
        @(negedge clk) clear_done_reg = 1'b0;
        check_val("clear_done_reg", done_reg, 0);
    endtask

    initial begin
        int snap;
        // Reset state
        @(negedge clk);
        check_val("rst_start", core_bus.start_mat_mul, 0);
        check_val("rst_done", done_reg, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_addr_a", core_bus.address_mat_a, 0);
        check_val("rst_busy_cycles", busy_cycles, 0);
        reset = 1'b0;

        // Three accumulated tiles
        clear_recs();
        num_k_tiles = 4'd3; base_addr_a = 10'h000; tile_step_a = 10'h040;
        base_addr_b = 10'h100; tile_step_b = 10'h008; base_addr_c = 10'h200;
        stride_a_in = 8'h08; stride_b_in = 8'h09; stride_c_in = 8'h0A;
        mask_a_rows_in = 8'hFF; mask_b_cols_in = 8'h7F; mask_k_full = 8'hFF; mask_k_last = 8'hFF;
        pulse_start();
        base_addr_a = 10'h155; num_k_tiles = 4'd9;
        wait_done("t3", 200);
        check_val("t3_starts", n_starts, 3);
        check_val("t3_a0", rec_a[0], 10'h000);
        check_val("t3_a1", rec_a[1], 10'h040);
        check_val("t3_a2", rec_a[2], 10'h080);
        check_val("t3_b0", rec_b[0], 10'h100);
        check_val("t3_b1", rec_b[1], 10'h108);
        check_val("t3_b2", rec_b[2], 10'h110);
        check_val("t3_sa0", rec_sa[0], 2'b10);
        check_val("t3_sa1", rec_sa[1], 2'b11);
        check_val("t3_sa2", rec_sa[2], 2'b01);
        check_val("t3_aborted", aborted, 0);
        check_val("t3_tile_idx", tile_idx, 2);
        check_val("t3_addr_c", core_bus.address_mat_c, 10'h200);
        check_val("t3_stride_b", core_bus.address_stride_b, 8'h09);
        check_val("t3_mask_cols", core_bus.validity_mask_b_cols, 8'h7F);
        check_val("t3_busy", busy, 0);
        check_val("t3_busy_cycles", busy_cycles, 27);
        $display("run t3: starts=%0d tile_idx=%0d busy_cycles=%0d", n_starts, tile_idx, busy_cycles);
        clear_done();

        // Last-tile K mask
        clear_recs();
        num_k_tiles = 4'd2; mask_k_full = 8'hFF; mask_k_last = 8'h0F;
        base_addr_a = 10'h000;
        pulse_start();
        wait_done("mk", 200);
        check_val("mk_starts", n_starts, 2);
        check_val("mk_tile0", rec_mk[0], 8'hFF);
        check_val("mk_tile1", rec_mk[1], 8'h0F);
        $display("run mk: starts=%0d", n_starts);
        clear_done();

        // Zero tiles
        clear_recs();
        num_k_tiles = 4'd0;
        pulse_start();
        check_val("z_done_next", done_reg, 1);
        repeat (3) @(negedge clk);
        check_val("z_starts", n_starts, 0);
        check_val("z_busy_cycles", busy_cycles, 0);
        $display("run zero: starts=%0d", n_starts);
        clear_done();

        // Abort during tile 1
        clear_recs();
        num_k_tiles = 4'd4;
        pulse_start();
        wait_starts("ab", 2, 200);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_done("ab", 200);
        repeat (20) @(negedge clk);
        check_val("ab_starts", n_starts, 2);
        check_val("ab_aborted", aborted, 1);
        check_val("ab_tile_idx", tile_idx, 1);
        $display("run abort: starts=%0d tile_idx=%0d", n_starts, tile_idx);
        clear_done();
        check_val("ab_aborted_clr", aborted, 0);

        // Address wrap
        clear_recs();
        num_k_tiles = 4'd2; base_addr_a = 10'h3F0; tile_step_a = 10'h020;
        pulse_start();
        wait_done("wr", 200);
        check_val("wr_a0", rec_a[0], 10'h3F0);
        check_val("wr_a1", rec_a[1], 10'h010);
        $display("run wrap: starts=%0d", n_starts);
        clear_done();

        // Asynchronous reset during tile 1 WAIT_DONE
        clear_recs();
        num_k_tiles = 4'd3; base_addr_a = 10'h040; tile_step_a = 10'h040;
        pulse_start();
        wait_starts("ar", 2, 200);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("ar_start", core_bus.start_mat_mul, 0);
        check_val("ar_addr_a", core_bus.address_mat_a, 0);
        check_val("ar_tile_idx", tile_idx, 0);
        check_val("ar_busy", busy, 0);
        check_val("ar_save", core_bus.save_output_to_accum, 0);
        check_val("ar_stride_a", core_bus.address_stride_a, 0);
        check_val("ar_busy_cycles", busy_cycles, 0);
        @(negedge clk) reset = 1'b0;

        // clear and start together in DONE must not launch a run
        num_k_tiles = 4'd0;
        pulse_start();
        check_val("cs_done", done_reg, 1);
        snap = n_starts;
        num_k_tiles = 4'd2;
        @(negedge clk) begin clear_done_reg = 1'b1; start_reg = 1'b1; end
        @(negedge clk) begin clear_done_reg = 1'b0; start_reg = 1'b0; end
        check_val("cs_done_clr", done_reg, 0);
        repeat (4) @(negedge clk);
        check_val("cs_busy", busy, 0);
        check_val("cs_starts", n_starts, snap);
        $display("run clr_start: starts=%0d busy=%0d", n_starts - snap, busy);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
Control block that runs a K-dimension tiled matrix multiply on the 8x8 matmul core without host intervention per tile. It replaces the single-shot start/done FSM in the memory-wrapped matmul top. On one start it issues NUM_K tiles to the core, advancing the A/B addresses each tile and driving the accumulate controls so that partial products sum in the core accumulator. It then holds a sticky done until the host clears it.

Parameters:
AWIDTH, 10, BRAM address width
ADDR_STRIDE_WIDTH, 8, core address-stride width
MASK_WIDTH, 8, validity-mask width (= MAT_MUL_SIZE)
TILE_CNT_WIDTH, 4, width of tile count/index (max 15 tiles)
PERF_WIDTH, 32, busy-cycle counter width

Ports:
clk  in  1  core clock
reset  in  1  async active-high reset
start_reg  in  1  level; sampled only in IDLE
clear_done_reg  in  1  level; sampled only in DONE
abort  in  1  level; stop after current tile handshake
num_k_tiles  in  TILE_CNT_WIDTH  tiles to run (0 = none)
base_addr_a / base_addr_b / base_addr_c  in  AWIDTH each  tile-0 addresses
tile_step_a / tile_step_b  in  AWIDTH each  per-tile address increment
stride_a_in / stride_b_in / stride_c_in  in  ADDR_STRIDE_WIDTH each  passed to core
mask_a_rows_in / mask_b_cols_in  in  MASK_WIDTH each  masks for every tile
mask_k_full / mask_k_last  in  MASK_WIDTH each  a_cols_b_rows mask: non-last tiles / last tile
done_mat_mul  in  1  from core
start_mat_mul  out  1  to core
address_mat_a / address_mat_b / address_mat_c  out  AWIDTH each  to core
address_stride_a / _b / _c  out  ADDR_STRIDE_WIDTH each  to core
save_output_to_accum / add_accum_to_output  out  1 each  to core
validity_mask_a_rows / validity_mask_a_cols_b_rows / validity_mask_b_cols  out  MASK_WIDTH each  to core
busy  out  1  high in any state except IDLE/DONE
done_reg  out  1  sticky completion
aborted  out  1  sticky; valid while done_reg
tile_idx  out  TILE_CNT_WIDTH  current tile
busy_cycles  out  PERF_WIDTH  cycles spent busy in last run, saturating

Behaviour:
- Reset (async, active-high): state IDLE. All outputs are 0, including addresses, masks, tile_idx and busy_cycles.
- All config inputs are latched into shadow registers on the IDLE->LAUNCH transition. Later input changes have no effect until the next run.
- States: IDLE, LAUNCH, WAIT_DONE, DRAIN, DONE.
- IDLE: start_reg=1 with num_k_tiles=0 -> DONE directly. done_reg=1, no start_mat_mul pulse. start_reg=1 with num_k_tiles>0 -> LAUNCH. On this transition: tile_idx=0, addr_a=base_a, addr_b=base_b, addr_c=base_c, busy_cycles=0.
- LAUNCH (1 cycle): drive the core control outputs as follows.
  - save_output_to_accum = (tile_idx != num_k_tiles-1)
  - add_accum_to_output = (tile_idx != 0)
  - validity_mask_a_cols_b_rows = last tile ? mask_k_last : mask_k_full
  - start_mat_mul <= 1
  - -> WAIT_DONE
- WAIT_DONE: start_mat_mul held 1 until done_mat_mul is sampled 1. Then start_mat_mul <= 0 -> DRAIN. Address and control outputs are stable for the whole tile.
- DRAIN: wait for done_mat_mul=0, then:
  - if abort was seen during this tile, or the last tile is complete -> DONE;
  - else tile_idx+1, addr_a += tile_step_a, addr_b += tile_step_b (modulo 2^AWIDTH, wrap silently) -> LAUNCH.
- Minimum per-tile overhead: 2 cycles (LAUNCH + DRAIN exit) beyond the core's own latency.
- abort: sampled every cycle while busy and latched as a pending flag. The current core handshake is never cut short. The sequencer completes WAIT_DONE/DRAIN, then goes to DONE with aborted=1. abort in IDLE/DONE is ignored.
- DONE: done_reg=1, busy=0. tile_idx and addresses hold their final values. clear_done_reg=1 -> IDLE, clearing done_reg and aborted. start_reg in DONE is ignored, including when asserted in the same cycle as clear_done_reg; it must be re-sampled in IDLE.
- busy_cycles increments every cycle busy=1 and saturates at all-ones.
- Stride and row/col mask outputs equal their latched values for the whole run.

Decomposition:
- Shared package: state encoding (IDLE=0, LAUNCH=1, WAIT_DONE=2, DRAIN=3, DONE=4, 3-bit) and default widths (AWIDTH, MASK_WIDTH, ADDR_STRIDE_WIDTH).
- Sub-module tile_addr_gen: base/step accumulator for one address with load and advance controls, instantiated twice (A, B).

Test Plan:
- num_k_tiles=3, base_a=0x000, step_a=0x040, base_b=0x100, step_b=0x008, core model with done 5 cycles after start -> address_mat_a 0x000/0x040/0x080 and address_mat_b 0x100/0x108/0x110. (save,add) = (1,0),(1,1),(0,1). done_reg=1, aborted=0, tile_idx=2.
- num_k_tiles=2, mask_k_full=0xFF, mask_k_last=0x0F -> validity_mask_a_cols_b_rows is 0xFF on tile 0 and 0x0F on tile 1.
- num_k_tiles=0, start_reg=1 -> done_reg=1 next cycle. start_mat_mul never asserted; busy_cycles=0.
- num_k_tiles=4, abort pulsed 1 cycle during tile 1 WAIT_DONE -> tile 1 handshake completes and no tile-2 start occurs. done_reg=1, aborted=1, tile_idx=1.
- base_a=0x3F0, step_a=0x020, AWIDTH=10, 2 tiles -> address_mat_a=0x3F0, then 0x010 (wrap).
- reset asserted mid-WAIT_DONE -> all outputs 0 immediately (async). Afterwards clear_done_reg+start_reg together in DONE -> IDLE with no new run started.
